// File: rtl/vesp_loader.sv
// Boot loader for vesp_risc: clears program memory, then assembles a big-endian byte
// stream into words, writes them from LOAD_BASE upward and finally releases the CPU.
module vesp_loader #(
    parameter int          word_size    = 16,
    parameter int          address_size = 12,
    parameter int unsigned FLUSH_DEPTH  = 256,
    parameter int unsigned LOAD_BASE    = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              in_data,
    input  logic                    in_valid,
    input  logic                    in_last,
    output logic                    in_ready,
    output logic                    mem_we,
    output logic [address_size-1:0] mem_addr,
    output logic [word_size-1:0]    mem_wdata,
    output logic                    cpu_run,
    output logic                    done,
    output logic                    err,
    output logic [8:0]              word_count
);

    localparam logic [1:0] FLUSH   = 2'd0;
    localparam logic [1:0] LOAD_HI = 2'd1;
    localparam logic [1:0] LOAD_LO = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    localparam int                      CW        = $clog2(FLUSH_DEPTH + 1);
    localparam logic [CW-1:0]           FLUSH_END = CW'(FLUSH_DEPTH);
    localparam logic [8:0]              LAST_WC   = 9'(FLUSH_DEPTH - 1);
    localparam logic [address_size-1:0] BASE      = address_size'(LOAD_BASE);

    logic [1:0]              state_q, state_d;
    logic [CW-1:0]           flush_cnt_q, flush_cnt_d;
    logic [7:0]              hi_q, hi_d;
    logic [8:0]              wc_q, wc_d;
    logic                    we_q, we_d;
    logic [address_size-1:0] addr_q, addr_d;
    logic [word_size-1:0]    wdata_q, wdata_d;
    logic                    err_q, err_d;
    // Set on the final word write; the write cycle itself must not accept more bytes.
    logic                    ending_q, ending_d;
    logic                    accept;

    assign in_ready   = (state_q == LOAD_HI || state_q == LOAD_LO) && !ending_q;
    assign accept     = in_valid && in_ready;
    assign done       = (state_q == DONE);
    assign cpu_run    = (state_q == DONE);
    assign mem_we     = we_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign err        = err_q;
    assign word_count = wc_q;

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        hi_d        = hi_q;
        wc_d        = wc_q;
        we_d        = 1'b0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        err_d       = err_q;
        ending_d    = ending_q;
        unique case (state_q)
            FLUSH: begin
                if (flush_cnt_q != FLUSH_END) begin
                    we_d        = 1'b1;
                    addr_d      = address_size'(flush_cnt_q);
                    wdata_d     = '0;
                    flush_cnt_d = flush_cnt_q + CW'(1);
                end else begin
                    state_d = LOAD_HI;
                end
            end
            LOAD_HI: begin
                if (accept) begin
                    if (in_last) begin
                        // Odd byte count: the dangling high byte is dropped.
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        hi_d    = in_data;
                        state_d = LOAD_LO;
                    end
                end
            end
            LOAD_LO: begin
                if (ending_q) begin
                    state_d = DONE;
                end else if (accept) begin
                    we_d    = 1'b1;
                    addr_d  = BASE + address_size'(wc_q);
                    wdata_d = word_size'({hi_q, in_data});
                    wc_d    = wc_q + 9'd1;
                    if (in_last) begin
                        ending_d = 1'b1;
                    end else if (wc_q == LAST_WC) begin
                        ending_d = 1'b1;
                        err_d    = 1'b1;
                    end else begin
                        state_d = LOAD_HI;
                    end
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = FLUSH;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FLUSH;
            flush_cnt_q <= '0;
            hi_q        <= '0;
            wc_q        <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            err_q       <= 1'b0;
            ending_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            hi_q        <= hi_d;
            wc_q        <= wc_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            err_q       <= err_d;
            ending_q    <= ending_d;
        end
    end

endmodule

// File: doc/vesp_loader.md
VESP_LOADER -- requirements
Module: vesp_loader

Interface
REQ-001 The block SHALL have parameter word_size, default 16, memory word width in bits.
REQ-002 The block SHALL have parameter address_size, default 12, memory address width in bits.
REQ-003 The block SHALL have parameter FLUSH_DEPTH, default 256, number of words cleared and maximum words loadable.
REQ-004 The block SHALL have parameter LOAD_BASE, default 0, first memory address written with program data.
REQ-005 The block SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-007 The block SHALL have port in_data, input, 8, program byte; the high byte of each word arrives first.
REQ-008 The block SHALL have port in_valid, input, 1, in_data is valid.
REQ-009 The block SHALL have port in_last, input, 1, qualifies the final byte of the program.
REQ-010 The block SHALL have port in_ready, output, 1, loader accepts a byte this cycle.
REQ-011 The block SHALL have port mem_we, output, 1, memory write strobe, one word per cycle.
REQ-012 The block SHALL have port mem_addr, output, address_size, memory write address.
REQ-013 The block SHALL have port mem_wdata, output, word_size, memory write data.
REQ-014 The block SHALL have port cpu_run, output, 1, drives the vesp_risc rst input; 0 holds the CPU in reset, 1 lets it execute.
REQ-015 The block SHALL have port done, output, 1, load sequence finished.
REQ-016 The block SHALL have port err, output, 1, load ended abnormally.
REQ-017 The block SHALL have port word_count, output, 9, number of program words written.

Function
REQ-018 The block SHALL implement states FLUSH, LOAD_HI, LOAD_LO and DONE.
REQ-019 In FLUSH the block SHALL assert mem_we with mem_wdata=0 and mem_addr=0,1,...,FLUSH_DEPTH-1 on consecutive cycles, then enter LOAD_HI; this takes exactly FLUSH_DEPTH cycles.
REQ-020 The block SHALL drive in_ready=1 only in LOAD_HI and LOAD_LO; a byte is accepted when in_valid and in_ready are both 1 on a rising edge.
REQ-021 In LOAD_HI an accepted byte SHALL be stored as the high byte, and the state SHALL become LOAD_LO.
REQ-022 In LOAD_LO an accepted byte SHALL cause, on the next cycle, mem_we=1, mem_addr=LOAD_BASE+word_count and mem_wdata={hi,lo}; word_count SHALL increment by 1 on that edge.
REQ-023 Word write latency SHALL be 1 cycle after acceptance of the low byte; sustained throughput SHALL be one byte per cycle with no bubbles.
REQ-024 An accepted low byte with in_last=1 SHALL write its word and then enter DONE.
REQ-025 An accepted high byte with in_last=1 (odd byte count) SHALL discard that byte, set err=1 and enter DONE.
REQ-026 If word_count reaches FLUSH_DEPTH without in_last, the block SHALL set err=1 and enter DONE after writing the last word; no address beyond LOAD_BASE+FLUSH_DEPTH-1 SHALL be written.
REQ-027 In DONE the block SHALL drive done=1, cpu_run=1 (even when err=1), in_ready=0 and mem_we=0, and SHALL remain there until rst.
REQ-028 In DONE, in_valid, in_data and in_last SHALL be ignored.
REQ-029 In LOAD_HI and LOAD_LO, cycles with in_valid=0 SHALL leave the state, held byte and word_count unchanged.
REQ-030 mem_we SHALL be 0 in every cycle where no write is specified; mem_addr and mem_wdata are don't-care when mem_we=0.

Reset
REQ-031 While rst=1, outputs SHALL be: state FLUSH, mem_we=0, mem_addr=0, mem_wdata=0, in_ready=0, cpu_run=0, done=0, err=0, word_count=0.
REQ-032 Assertion of rst in any state, including mid-flush or mid-word, SHALL drop cpu_run and mem_we immediately (asynchronously), discard any held high byte, and restart at FLUSH address 0 after release.
REQ-033 The first flush write (address 0) SHALL occur on the first rising edge after rst deasserts.

Verification
REQ-034 Release rst, send no bytes -> 256 consecutive mem_we pulses with addresses 0..255 and data 0; in_ready rises on the next cycle; cpu_run stays 0.
REQ-035 After flush, stream 20 00 14 58 80 00 D0 00 70 00 with in_last on the final byte and in_valid held high -> writes [0]=2000, [1]=1458, [2]=8000, [3]=D000, [4]=7000 on consecutive odd cycles; word_count=5, done=1, cpu_run=1, err=0.
REQ-036 Same stream with random in_valid gaps -> identical memory contents and word_count=5; no writes during gaps.
REQ-037 Send 3 bytes 20 00 14 with in_last on 14 -> [0]=2000 only, err=1, done=1, word_count=1.
REQ-038 Send 257 words without in_last -> addresses 0..255 written, err=1 after word 256, the 257th word is not accepted, and in_ready=0.
REQ-039 Assert rst after the high byte of word 2 -> cpu_run=0 at once; after release, flush restarts at address 0 and the prior high byte never appears in memory.
